// File: rtl/apb2per_pkg.sv
// apb2per_pkg: FSM state type and legal data widths shared by the apb2per_bridge files.
package apb2per_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_e;
    localparam int unsigned DATA_WIDTH_32 = 32;
    localparam int unsigned DATA_WIDTH_64 = 64;
    localparam int unsigned CNT_WIDTH = 16;
endpackage

// File: rtl/apb2per_timeout.sv
// apb2per_timeout: response-timeout counter, present only in builds with APB2PER_TIMEOUT_EN.
module apb2per_timeout import apb2per_pkg::*; #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear_i ? '0 : enable_i ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    // Fires in the cycle whose edge brings the count to LIMIT, so the FSM leaves on that edge.
    assign expired_o = enable_i && cnt_q == CNT_WIDTH'(LIMIT - 1);
endmodule

// File: rtl/apb2per_bridge.sv
// apb2per_bridge: APB slave to peripheral-master bridge with fully registered outputs.
// Define APB2PER_TIMEOUT_EN to end stalled transfers with PSLVERR after TIMEOUT_CYCLES.
module apb2per_bridge import apb2per_pkg::*; #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned PER_ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [STRB_WIDTH-1:0]     PSTRB,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      per_master_req_o,
    output logic [PER_ADDR_WIDTH-1:0] per_master_add_o,
    output logic                      per_master_we_o,
    output logic [DATA_WIDTH-1:0]     per_master_wdata_o,
    output logic [STRB_WIDTH-1:0]     per_master_be_o,
    input  logic                      per_master_gnt_i,
    input  logic                      per_master_r_valid_i,
    input  logic                      per_master_r_opc_i,
    input  logic [DATA_WIDTH-1:0]     per_master_r_rdata_i
);
    state_e                    state_q, state_d;
    logic                      err_q, err_d;
    logic                      req_q, req_d;
    logic                      we_q, we_d;
    logic [PER_ADDR_WIDTH-1:0] add_q, add_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]     be_q, be_d;
    logic [DATA_WIDTH-1:0]     prdata_q, prdata_d;
    logic                      pready_q, pready_d;
    logic                      pslverr_q, pslverr_d;
    logic                      expired;

`ifdef APB2PER_TIMEOUT_EN
    apb2per_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk_i,
        .rst_ni,
        .clear_i  (state_q == IDLE && state_d == REQ),
        .enable_i (state_q == REQ || state_q == WAIT_R),
        .expired_o(expired)
    );
`else
    // No counter: never true for a legal limit, so the FSM waits on the peripheral indefinitely.
    assign expired = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        req_d    = req_q;
        we_d     = we_q;
        add_d    = add_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        prdata_d = prdata_q;
        case (state_q)
            IDLE: if (PSEL && PENABLE) begin
                state_d = REQ;
                req_d   = 1'b1;
                we_d    = PWRITE;
                add_d   = PER_ADDR_WIDTH'(PADDR);
                wdata_d = PWDATA;
                be_d    = PWRITE ? PSTRB : '1;
            end
            REQ: if (per_master_gnt_i) begin
                state_d = we_q ? RESP : WAIT_R;
                req_d   = 1'b0;
                err_d   = 1'b0;
            end else if (expired) begin
                state_d = RESP;
                req_d   = 1'b0;
                err_d   = 1'b1;
            end
            WAIT_R: if (per_master_r_valid_i) begin
                state_d  = RESP;
                prdata_d = per_master_r_rdata_i;
                err_d    = per_master_r_opc_i;
            end else if (expired) begin
                state_d = RESP;
                err_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // RESP always lasts one cycle, so registering its entry gives a single PREADY pulse.
        pready_d  = state_d == RESP;
        pslverr_d = state_d == RESP && err_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            err_q     <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            add_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            req_q     <= req_d;
            we_q      <= we_d;
            add_q     <= add_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign PRDATA             = prdata_q;
    assign PREADY             = pready_q;
    assign PSLVERR            = pslverr_q;
    assign per_master_req_o   = req_q;
    assign per_master_add_o   = add_q;
    assign per_master_we_o    = we_q;
    assign per_master_wdata_o = wdata_q;
    assign per_master_be_o    = be_q;
endmodule

// File: tb/tb_apb2per_bridge.sv
// tb_apb2per_bridge: randomized scoreboard bench for apb2per_bridge against a transfer-level model.
`timescale 1ns/1ps
module tb_apb2per_bridge;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [31:0] PADDR, PWDATA, PRDATA, add, wdata, rdata;
    logic [3:0]  PSTRB, be;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR, req, we, gnt, rv, opc;

    apb2per_bridge u_dut (
        .clk_i, .rst_ni, .PADDR, .PWDATA, .PSTRB, .PWRITE, .PSEL, .PENABLE,
        .PRDATA, .PREADY, .PSLVERR,
        .per_master_req_o(req), .per_master_add_o(add), .per_master_we_o(we),
        .per_master_wdata_o(wdata), .per_master_be_o(be),
        .per_master_gnt_i(gnt), .per_master_r_valid_i(rv),
        .per_master_r_opc_i(opc), .per_master_r_rdata_i(rdata)
    );

    logic [31:0] b_paddr;
    logic [63:0] b_pwdata, b_prdata, b_wdata, b_rdata;
    logic [7:0]  b_pstrb, b_be;
    logic [15:0] b_add;
    logic        b_pwrite, b_psel, b_penable, b_pready, b_pslverr, b_req, b_we, b_gnt, b_rv, b_opc;

    apb2per_bridge #(.PER_ADDR_WIDTH(16), .DATA_WIDTH(64), .TIMEOUT_CYCLES(4)) u_dut_b (
        .clk_i, .rst_ni, .PADDR(b_paddr), .PWDATA(b_pwdata), .PSTRB(b_pstrb),
        .PWRITE(b_pwrite), .PSEL(b_psel), .PENABLE(b_penable),
        .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr),
        .per_master_req_o(b_req), .per_master_add_o(b_add), .per_master_we_o(b_we),
        .per_master_wdata_o(b_wdata), .per_master_be_o(b_be),
        .per_master_gnt_i(b_gnt), .per_master_r_valid_i(b_rv),
        .per_master_r_opc_i(b_opc), .per_master_r_rdata_i(b_rdata)
    );

    typedef struct {
        logic [31:0] add, wdata, rdata;
        logic [3:0]  be;
        logic        we, opc;
        int          gd, rd;
    } per_t;
    typedef struct {
        logic [31:0] prdata;
        logic        err;
        int          lat, t0;
    } rsp_t;

    per_t        pq[$];
    rsp_t        rq[$];
    logic [31:0] last_rdata = '0;
    int          checks = 0, errors = 0, cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Peripheral slave: grants after gd cycles, answers reads rd cycles after grant,
    // and sprinkles junk r_valid while the request is still pending.
    initial begin : responder
        per_t it;
        gnt = 1'b0; rv = 1'b0; opc = 1'b0; rdata = '0;
        forever begin
            @(negedge clk_i);
            gnt = 1'b0; rv = 1'b0; rdata = $urandom; opc = 1'($urandom);
            if (req && pq.size() == 0) check("req_unexpected", req, 1'b0);
            else if (req) begin
                it = pq.pop_front();
                check("add", add, it.add);
                check("we", we, it.we);
                check("be", be, it.be);
                if (it.we) check("wdata", wdata, it.wdata);
                for (int i = 0; i < it.gd; i++) begin
                    rv = 1'($urandom);
                    @(negedge clk_i);
                    rv = 1'b0;
                    check("req_held", {req, add}, {1'b1, it.add});
                end
                gnt = 1'b1; rv = 1'($urandom);
                @(negedge clk_i);
                gnt = 1'b0; rv = 1'b0;
                check("req_drop", req, 1'b0);
                if (!it.we) begin
                    repeat (it.rd) @(negedge clk_i);
                    rv = 1'b1; rdata = it.rdata; opc = it.opc;
                end
            end
        end
    end

    initial begin : monitor
        rsp_t r;
        forever begin
            @(negedge clk_i);
            if (!PREADY) check("pslverr_low", PSLVERR, 1'b0);
            else if (rq.size() == 0) check("pready_spurious", PREADY, 1'b0);
            else begin
                r = rq.pop_front();
                check("prdata", PRDATA, r.prdata);
                check("pslverr", PSLVERR, r.err);
                check("latency", cyc - r.t0, r.lat);
            end
        end
    end

    task automatic xfer(input logic w, input logic [31:0] a, d, input logic [3:0] s,
                        input int gd, rd, input logic [31:0] rdat, input logic op, input logic drop);
        per_t p;
        rsp_t r;
        logic done;
        p.add = a; p.wdata = d; p.we = w; p.be = w ? s : 4'hF;
        p.gd = gd; p.rd = rd; p.rdata = rdat; p.opc = op;
        pq.push_back(p);
        if (!w) last_rdata = rdat;
        r.prdata = last_rdata;
        r.err = !w && op;
        r.lat = w ? 2 + gd : 3 + gd + rd;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d; PSTRB = s; PWRITE = w;
        @(negedge clk_i);
        PENABLE = 1'b1;
        r.t0 = cyc;
        rq.push_back(r);
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_i);
            if (drop) begin PSEL = 1'b0; PENABLE = 1'b0; end
            done = PREADY;
        end
        if (!done) check("pready_timeout", 1'b0, 1'b1);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        per_t p;
        logic [63:0] b_last;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0; PSTRB = '0;
        b_psel = 1'b0; b_penable = 1'b0; b_pwrite = 1'b0; b_paddr = '0; b_pwdata = '0; b_pstrb = '0;
        b_gnt = 1'b0; b_rv = 1'b0; b_opc = 1'b0; b_rdata = '0;
        repeat (2) @(negedge clk_i);
        check("rst_outputs", {PRDATA, PREADY, PSLVERR, req, add, we, wdata, be}, '0);
        check("rst_outputs_b", {b_prdata, b_pready, b_pslverr, b_req, b_add, b_we, b_be}, '0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        xfer(1'b1, 32'h1A10_0004, 32'hDEAD_BEEF, 4'h3, 0, 0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk_i);
        xfer(1'b0, 32'h0000_0100, '0, 4'h0, 3, 2, 32'h1234_5678, 1'b0, 1'b0);
        xfer(1'b0, 32'h0000_0200, '0, 4'h5, 0, 0, 32'hBAD0_0001, 1'b1, 1'b0);
        xfer(1'b1, 32'h0000_0300, 32'h0BAD_CAFE, 4'hF, 1, 0, '0, 1'b0, 1'b1);

        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h44; PWRITE = 1'b1;
        repeat (3) @(negedge clk_i);
        check("setup_no_req", req, 1'b0);
        PSEL = 1'b0;
        @(negedge clk_i);

        p.add = 32'h0000_0500; p.we = 1'b0; p.be = 4'hF; p.wdata = '0;
        p.gd = 0; p.rd = 8; p.rdata = 32'h5555_AAAA; p.opc = 1'b0;
        pq.push_back(p);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = p.add; PWRITE = 1'b0;
        @(negedge clk_i);
        PENABLE = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("rst_mid_outputs", {PRDATA, PREADY, PSLVERR, req, add, we, wdata, be}, '0);
        PSEL = 1'b0; PENABLE = 1'b0;
        last_rdata = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk_i);
        xfer(1'b0, 32'h0000_0600, '0, 4'h0, 1, 1, 32'h600D_0600, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            xfer(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end
        repeat (6) @(negedge clk_i);
        check("pq_drained", pq.size(), 0);
        check("rq_drained", rq.size(), 0);

        b_psel = 1'b1; b_paddr = 32'h0001_2344; b_pwrite = 1'b0; b_pstrb = 8'h0;
        @(negedge clk_i);
        b_penable = 1'b1;
        @(negedge clk_i);
        check("b_req", {b_req, b_we, b_add, b_be}, {1'b1, 1'b0, 16'h2344, 8'hFF});
        b_gnt = 1'b1;
        @(negedge clk_i);
        b_gnt = 1'b0;
        check("b_req_drop", b_req, 1'b0);
        b_rv = 1'b1; b_rdata = 64'hCAFE_F00D_1234_5678; b_opc = 1'b0;
        @(negedge clk_i);
        b_rv = 1'b0; b_psel = 1'b0; b_penable = 1'b0;
        check("b_resp", {b_pready, b_pslverr, b_prdata}, {1'b1, 1'b0, 64'hCAFE_F00D_1234_5678});
        b_last = 64'hCAFE_F00D_1234_5678;
        @(negedge clk_i);
        check("b_pready_pulse", b_pready, 1'b0);

`ifdef APB2PER_TIMEOUT_EN
        b_psel = 1'b1; b_paddr = 32'h0000_0040; b_pwrite = 1'b0;
        @(negedge clk_i);
        b_penable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i);
            b_psel = 1'b0; b_penable = 1'b0;
            check("to_req_held", {b_req, b_pready}, {1'b1, 1'b0});
        end
        @(negedge clk_i);
        check("to_resp", {b_req, b_pready, b_pslverr, b_prdata}, {1'b0, 1'b1, 1'b1, b_last});
        b_rv = 1'b1; b_opc = 1'b1; b_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk_i);
        check("to_pulse", b_pready, 1'b0);
        @(negedge clk_i);
        b_rv = 1'b0;
        check("to_late_rvalid", {b_pready, b_pslverr, b_prdata}, {1'b0, 1'b0, b_last});
`endif

        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb2per_bridge.md
APB2PER_BRIDGE -- requirements
Module: apb2per_bridge

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 32, SHALL set the PADDR width.
REQ-002 Parameter PER_ADDR_WIDTH, default 32, SHALL set the per_master_add_o width; narrower SHALL truncate MSBs, wider SHALL zero-extend.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set the data width; legal values are 32 and 64. STRB_WIDTH = DATA_WIDTH/8.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, SHALL set the response timeout limit; range 1..65535.
REQ-005 Ports SHALL be:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- PADDR  in  APB_ADDR_WIDTH  APB address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  STRB_WIDTH  write strobes
- PWRITE  in  1  direction
- PSEL  in  1  select
- PENABLE  in  1  access phase
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error
- per_master_req_o  out  1  request
- per_master_add_o  out  PER_ADDR_WIDTH  address
- per_master_we_o  out  1  write enable
- per_master_wdata_o  out  DATA_WIDTH  write data
- per_master_be_o  out  STRB_WIDTH  byte enables
- per_master_gnt_i  in  1  grant
- per_master_r_valid_i  in  1  response valid
- per_master_r_opc_i  in  1  response error (1 = error)
- per_master_r_rdata_i  in  DATA_WIDTH  read data

Function
REQ-006 All outputs SHALL be driven from registers.
REQ-007 FSM states SHALL be IDLE, REQ, WAIT_R and RESP.
REQ-008 In IDLE, PSEL=1 and PENABLE=1 SHALL capture the address, data, direction and byte enables, then move to REQ; a setup phase (PENABLE=0) SHALL NOT start a transfer.
REQ-009 Byte enables SHALL equal PSTRB for writes and all-ones for reads.
REQ-010 In REQ, per_master_req_o SHALL be 1 and the request outputs SHALL hold stable until per_master_gnt_i=1.
REQ-011 On grant of a write, the FSM SHALL go to RESP with error cleared.
REQ-012 On grant of a read, the FSM SHALL go to WAIT_R; per_master_req_o SHALL drop the cycle after grant.
REQ-013 In WAIT_R, per_master_r_valid_i=1 SHALL capture r_rdata into PRDATA and r_opc into the error flag, then move to RESP.
REQ-014 In RESP, PREADY SHALL be 1 for exactly one cycle, PSLVERR SHALL equal the error flag, and the FSM SHALL then return to IDLE.
REQ-015 PSLVERR SHALL be 0 whenever PREADY=0.
REQ-016 Minimum latency from the access-phase cycle T0 to PREADY SHALL be:
- write: PREADY at T2 (grant at T1)
- read: PREADY at T3 (grant at T1, r_valid at T2)
REQ-017 per_master_r_valid_i SHALL be ignored outside WAIT_R.
REQ-018 Back-to-back transfers SHALL be supported; the next access phase is accepted in IDLE the cycle after RESP.
REQ-019 PSEL deasserting mid-transfer (an APB protocol violation) SHALL NOT abort the transfer; the FSM completes normally.
REQ-020 PRDATA SHALL hold its last captured value until the next read response.

Reset
REQ-021 Asserting rst_ni SHALL immediately force state IDLE, all outputs 0, counter 0 and error flag 0, including mid-transfer; no response is then generated.

Configuration
REQ-022 With APB2PER_TIMEOUT_EN defined, a counter SHALL:
- clear on entry to REQ
- increment each cycle in REQ or WAIT_R
- on reaching TIMEOUT_CYCLES, drop per_master_req_o, set the error flag and go to RESP (PREADY=1, PSLVERR=1, PRDATA unchanged)
REQ-023 Without APB2PER_TIMEOUT_EN, no counter SHALL be present and the FSM SHALL wait indefinitely.

Structure
REQ-024 Package apb2per_pkg SHALL hold the FSM state enum and the legal DATA_WIDTH constants.
REQ-025 The timeout counter SHALL be sub-module apb2per_timeout (ports: clear, enable, expired), instantiated only under APB2PER_TIMEOUT_EN.

Verification
REQ-026 The bench SHALL cover at least these directed scenarios:
- Write, PADDR=0x1A10_0004, PWDATA=0xDEAD_BEEF, PSTRB=0x3, grant at T1 -> add=0x1A10_0004, be=0x3, PREADY at T2, PSLVERR=0.
- Read, grant delayed 3 cycles, r_valid 2 cycles after grant, rdata=0x1234_5678, r_opc=0 -> req held 4 cycles, PRDATA=0x1234_5678, single PREADY pulse.
- Read with r_opc=1 -> PREADY=1 and PSLVERR=1 in the same cycle.
- TIMEOUT_CYCLES=4, macro defined, gnt tied 0 -> req drops after 4 cycles, PREADY=1 and PSLVERR=1; a late r_valid is ignored.
- rst_ni asserted in WAIT_R -> all outputs 0; the next read completes normally.
- DATA_WIDTH=64, PER_ADDR_WIDTH=16, PADDR=0x0001_2344 -> add=0x2344, read be=0xFF.
